cpu_sequencer: RTL and testbench

- Eight-phase instruction sequencer for the basic CPU.
- Drives memory read/write, the instruction-register load strobe and the program-counter/accumulator controls.
- Consumes the 3-bit opcode held by the instruction register (instruction byte bits [7:5]) and the accumulator zero flag.
- One instruction takes exactly 8 enabled clock cycles.

---
 rtl/cpu_sequencer.sv | 137 +++++++++++++
 tb/tb_cpu_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase instruction sequencer for the basic CPU.
// One instruction takes exactly 8 enabled cycles. The phase register and the
// halted flag are the only state. Every output is decoded combinationally from
// that state and from enable, opcode and zero.
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   enable        1 = advance one phase per cycle, 0 = stall
//   opcode        IR[7:5]; decoded only in phases 4..7
//   zero          accumulator == 0
//   sel           address mux (1 = PC, 0 = IR operand)
//   rd, wr        memory read enable / write strobe
//   ld_ir         IR load strobe
//   inc_pc, ld_pc PC increment / load strobes
//   ld_ac         accumulator load strobe
//   data_e        accumulator drives the data bus
//   halt          processor halted (or about to halt)
//   phase         current phase, for trace
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e state, state_nxt;
  logic   halted, halted_nxt;

  // Raw strobe decode, before gating with enable.
  logic s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_wr;
  logic aluop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    halted_nxt = halted;
    sel        = 1'b0;
    rd         = 1'b0;
    data_e     = 1'b0;
    halt       = 1'b0;
    s_ld_ir    = 1'b0;
    s_inc_pc   = 1'b0;
    s_ld_pc    = 1'b0;
    s_ld_ac    = 1'b0;
    s_wr       = 1'b0;
    aluop      = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

    // A stall blocks every state change, halt entry included.
    if (!halted && enable) begin
      if (state == OP_ADDR && opcode == OP_HLT) halted_nxt = 1'b1;
      else                                      state_nxt  = phase_e'(state + 3'd1);
    end

    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (state)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD, IDLE: begin
          // IR captures on both edges; opcode is stable from phase 3 on.
          sel = 1'b1; rd = 1'b1; s_ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt     = (opcode == OP_HLT);
          s_inc_pc = (opcode != OP_HLT);
        end
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd       = aluop;
          s_inc_pc = (opcode == OP_SKZ) && zero;
          s_ld_pc  = (opcode == OP_JMP);
          data_e   = (opcode == OP_STO);
        end
        STORE: begin
          // Bus is already driven in phase 6, so data is settled before wr.
          rd      = aluop;
          s_ld_ac = aluop;
          s_ld_pc = (opcode == OP_JMP);
          s_wr    = (opcode == OP_STO);
          data_e  = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  // Strobes are edge-effective actions and must not repeat during a stall;
  // level outputs keep their phase decode.
  assign ld_ir  = s_ld_ir  & enable;
  assign inc_pc = s_inc_pc & enable;
  assign ld_pc  = s_ld_pc  & enable;
  assign ld_ac  = s_ld_ac  & enable;
  assign wr     = s_wr     & enable;
  assign phase  = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,phase}
  logic [11:0] obs, exp_v;
  assign obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};

  int vecs = 0;
  int errs = 0;

  // Reference model: instruction progress counter plus halted flag.
  int m_ph = 0;
  bit m_halt = 1'b0;

  function automatic logic [11:0] model_out(int ph, bit hl, bit en, int op, bit z);
    bit alu, o_sel, o_rd, o_ldir, o_inc, o_ldpc, o_ldac, o_wr, o_de, o_hlt;
    alu = (op >= 2 && op <= 5);
    if (hl) return {9'b0_0000_0001, 3'd4};
    o_sel  = (ph <= 3);
    o_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    o_ldir = en && (ph == 2 || ph == 3);
    o_inc  = en && ((ph == 4 && op != 0) || (ph == 6 && op == 1 && z));
    o_ldpc = en && (ph == 6 || ph == 7) && op == 7;
    o_ldac = en && ph == 7 && alu;
    o_wr   = en && ph == 7 && op == 6;
    o_de   = (ph == 6 || ph == 7) && op == 6;
    o_hlt  = (ph == 4 && op == 0);
    return {o_sel, o_rd, o_ldir, o_inc, o_ldpc, o_ldac, o_wr, o_de, o_hlt, 3'(ph)};
  endfunction

  // One clock edge; the model advances from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst && !m_halt && enable) begin
      if (m_ph == 4 && opcode == 3'd0) m_halt = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
    #2;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1; m_ph = 0; m_halt = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ph = 0; m_halt = 1'b0;
    enable = 1'b1; opcode = 3'd6;
    #1;
    vecs++;
    if (obs !== 12'b1000_0000_0000) begin
      $display("FAIL reset_state got=%b exp=%b", obs, 12'b1000_0000_0000); errs++;
    end
    rst = 1'b0;
  endtask

  task automatic test_instr(input logic [2:0] op, input bit z, input int exp_inc);
    int incs = 0;
    do_reset();
    enable = 1'b1; opcode = op; zero = z;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_v = model_out(m_ph, m_halt, enable, opcode, zero);
      vecs++;
      if (obs !== exp_v) begin
        $display("FAIL instr op=%0d z=%0d cyc=%0d got=%b exp=%b", op, z, c, obs, exp_v); errs++;
      end
      if (inc_pc) incs++;
      tick();
    end
    vecs++;
    if (incs != exp_inc || phase !== 3'd0) begin
      $display("FAIL instr_inc op=%0d got=%0d/ph%0d exp=%0d/ph0", op, incs, phase, exp_inc); errs++;
    end
  endtask

  task automatic test_halt();
    do_reset();
    enable = 1'b1; opcode = 3'd0; zero = 1'($urandom_range(1));
    for (int c = 0; c < 4; c++) tick();
    #1;
    vecs++;
    if (phase !== 3'd4 || halt !== 1'b1 || inc_pc !== 1'b0) begin
      $display("FAIL halt_entry got=ph%0d h%0d i%0d exp=ph4 h1 i0", phase, halt, inc_pc); errs++;
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      opcode = 3'($urandom);
      #1;
      exp_v = model_out(m_ph, m_halt, enable, opcode, zero);
      vecs++;
      if (obs !== exp_v || obs !== 12'b0000_0000_1100) begin
        $display("FAIL halted cyc=%0d got=%b exp=%b", c, obs, exp_v); errs++;
      end
    end
    rst = 1'b1; m_ph = 0; m_halt = 1'b0;
    #1;
    vecs++;
    if (phase !== 3'd0 || halt !== 1'b0) begin
      $display("FAIL halt_reset got=ph%0d h%0d exp=ph0 h0", phase, halt); errs++;
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (phase !== 3'd1) begin
      $display("FAIL halt_resume got=ph%0d exp=ph1", phase); errs++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    enable = 1'b1; opcode = 3'($urandom); zero = 1'($urandom_range(1));
    tick(); tick();
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      exp_v = model_out(m_ph, m_halt, enable, opcode, zero);
      vecs++;
      if (obs !== exp_v || phase !== 3'd2 || ld_ir !== 1'b0 || rd !== 1'b1 || sel !== 1'b1) begin
        $display("FAIL stall cyc=%0d got=%b exp=%b", c, obs, exp_v); errs++;
      end
      tick();
    end
    enable = 1'b1;
    tick();
    vecs++;
    if (phase !== 3'd3) begin
      $display("FAIL stall_resume got=ph%0d exp=ph3", phase); errs++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; opcode = 3'd6;
    for (int c = 0; c < 7; c++) tick();
    #1;
    vecs++;
    if (wr !== 1'b1 || phase !== 3'd7) begin
      $display("FAIL sto_wr got=wr%0d ph%0d exp=wr1 ph7", wr, phase); errs++;
    end
    rst = 1'b1; m_ph = 0; m_halt = 1'b0;
    #1;
    vecs++;
    if (obs !== 12'b1000_0000_0000) begin
      $display("FAIL reset_mid got=%b exp=%b", obs, 12'b1000_0000_0000); errs++;
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(3) != 0);
      opcode = 3'($urandom);
      zero   = 1'($urandom_range(1));
      if ($urandom_range(24) == 0) begin
        rst = 1'b1; m_ph = 0; m_halt = 1'b0;
      end
      #1;
      exp_v = model_out(m_ph, m_halt, enable, opcode, zero);
      vecs++;
      if (obs !== exp_v) begin
        $display("FAIL random cyc=%0d got=%b exp=%b", c, obs, exp_v); errs++;
      end
      rst = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_instr(3'd2, 1'b0, 1);
    test_instr(3'd6, 1'($urandom_range(1)), 1);
    test_instr(3'd1, 1'b1, 2);
    test_instr(3'd1, 1'b0, 1);
    test_instr(3'd7, 1'($urandom_range(1)), 1);
    test_instr(3'd3, 1'($urandom_range(1)), 1);
    test_halt();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
